// File: rtl/updown_count_sequencer_pkg.sv
// Shared constants for the up/down count sequencer: FSM state codes and
// counter mode encodings used by the top level and the counter core.
package updown_count_sequencer_pkg;

    typedef logic [1:0] seqState_t;

    localparam seqState_t ST_IDLE = 2'd0;
    localparam seqState_t ST_RUN  = 2'd1;
    localparam seqState_t ST_DONE = 2'd2;

    localparam logic MODE_UP   = 1'b0;
    localparam logic MODE_DOWN = 1'b1;

endpackage : updown_count_sequencer_pkg

// File: rtl/updown_count_sequencer_core.sv
// Synchronous up/down counter datapath. When t is high, q moves by one in the
// direction given by m; otherwise it holds. Wraps modulo 2^WIDTH by design,
// since keeping the count in range is the sequencer's job.
module updown_counter_core
    import updown_count_sequencer_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             t,
    input  logic             m,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Next count: step up or down when enabled, otherwise hold.
    always_comb begin
        q_d = q_q;
        if (t) begin
            if (m == MODE_DOWN) begin
                q_d = q_q - WIDTH'(1);
            end else begin
                q_d = q_q + WIDTH'(1);
            end
        end
    end

    // Count register with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule : updown_counter_core

// File: rtl/updown_count_sequencer.sv
// Sequencer that drives an up/down counter core towards a commanded target.
// A command is taken over a valid/ready port, the direction is chosen once at
// accept time, and the counter then steps once per cycle until it matches the
// target. Pause freezes the run; abort drops it without signalling done.
module updown_count_sequencer
    import updown_count_sequencer_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_target,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] cnt,
    output logic             cnt_en,
    output logic             cnt_mode,
    output logic             busy,
    output logic             done
);

    seqState_t        state_q;
    seqState_t        state_d;
    logic [WIDTH-1:0] target_q;
    logic [WIDTH-1:0] target_d;
    logic             mode_q;
    logic             mode_d;

    logic             accept;
    logic [WIDTH-1:0] stepVal;

    // Handshake, counter enable and the value the counter will hold after a step.
    always_comb begin
        cmd_ready = (state_q != ST_RUN);
        accept    = cmd_valid & cmd_ready;
        cnt_en    = (state_q == ST_RUN) & ~pause & ~abort;
        if (mode_q == MODE_DOWN) begin
            stepVal = cnt - WIDTH'(1);
        end else begin
            stepVal = cnt + WIDTH'(1);
        end
    end

    // FSM next state; direction and target are only updated on an accept.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        mode_d   = mode_q;
        case (state_q)
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (cnt_en && (stepVal == target_q)) begin
                    state_d = ST_DONE;
                end
            end
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    target_d = cmd_target;
                    if (cmd_target > cnt) begin
                        mode_d  = MODE_UP;
                        state_d = ST_RUN;
                    end else if (cmd_target < cnt) begin
                        mode_d  = MODE_DOWN;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, target and mode registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            target_q <= '0;
            mode_q   <= MODE_UP;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            mode_q   <= mode_d;
        end
    end

    updown_counter_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk(clk),
        .rst(rst),
        .t  (cnt_en),
        .m  (mode_q),
        .q  (cnt)
    );

    assign cnt_mode = mode_q;
    assign busy     = (state_q == ST_RUN);
    assign done     = (state_q == ST_DONE);

endmodule : updown_count_sequencer

// File: tb/tb_updown_count_sequencer.sv
// Testbench for updown_count_sequencer: directed command sequences with
// literal expectations, plus a run-level model compared every cycle.
module tb_updown_count_sequencer;

    localparam int PH_IDLE = 0;
    localparam int PH_RUN  = 1;
    localparam int PH_DONE = 2;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_target;
    logic       pause;
    logic       abort;
    logic [2:0] cnt;
    logic       cnt_en;
    logic       cnt_mode;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;
    bit modelOn  = 0;

    int mPhase  = PH_IDLE;
    int mCnt    = 0;
    int mTarget = 0;
    int mMode   = 0;

    updown_count_sequencer #(
        .WIDTH(3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_target(cmd_target),
        .pause     (pause),
        .abort     (abort),
        .cnt       (cnt),
        .cnt_en    (cnt_en),
        .cnt_mode  (cnt_mode),
        .busy      (busy),
        .done      (done)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Drive one input vector just after a rising edge and hold it for n edges.
    task automatic applyStimulus(input logic v, input logic [2:0] t, input logic p,
                                 input logic a, input int n);
        cmd_valid  = v;
        cmd_target = t;
        pause      = p;
        abort      = a;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Run-level model: a run walks the integer count one unit per unpaused
    // cycle toward the target; an int count exposes any wrap in the DUT.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mPhase  <= PH_IDLE;
            mCnt    <= 0;
            mTarget <= 0;
            mMode   <= 0;
        end else if (mPhase == PH_RUN) begin
            if (abort) begin
                mPhase <= PH_IDLE;
            end else if (!pause) begin
                mCnt <= mCnt + ((mMode == 1) ? -1 : 1);
                if (mCnt + ((mMode == 1) ? -1 : 1) == mTarget) mPhase <= PH_DONE;
            end
        end else if (cmd_valid) begin
            mTarget <= int'(cmd_target);
            if (int'(cmd_target) > mCnt) begin
                mMode  <= 0;
                mPhase <= PH_RUN;
            end else if (int'(cmd_target) < mCnt) begin
                mMode  <= 1;
                mPhase <= PH_RUN;
            end else begin
                mPhase <= PH_DONE;
            end
        end else begin
            mPhase <= PH_IDLE;
        end
    end

    // Per-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst && modelOn) begin
            checkOutput("cyc_cnt", int'(cnt), mCnt);
            checkOutput("cyc_mode", int'(cnt_mode), mMode);
            checkOutput("cyc_busy", int'(busy), (mPhase == PH_RUN) ? 1 : 0);
            checkOutput("cyc_done", int'(done), (mPhase == PH_DONE) ? 1 : 0);
            checkOutput("cyc_ready", int'(cmd_ready), (mPhase != PH_RUN) ? 1 : 0);
            checkOutput("cyc_en", int'(cnt_en),
                        (mPhase == PH_RUN && !pause && !abort) ? 1 : 0);
        end
    end

    // Directed scenarios.
    initial begin
        rst        = 1'b0;
        cmd_valid  = 1'b0;
        cmd_target = 3'd0;
        pause      = 1'b0;
        abort      = 1'b0;
        #2;
        checkOutput("rst_cnt", int'(cnt), 0);
        checkOutput("rst_mode", int'(cnt_mode), 0);
        checkOutput("rst_ready", int'(cmd_ready), 1);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        #10;
        rst = 1'b1;
        @(posedge clk);
        #1;
        modelOn = 1;

        // Up run 0 -> 5.
        applyStimulus(1, 3'd5, 0, 0, 1);
        checkOutput("up_busy", int'(busy), 1);
        checkOutput("up_mode", int'(cnt_mode), 0);
        applyStimulus(0, 3'd0, 0, 0, 4);
        checkOutput("up_cnt4", int'(cnt), 4);
        checkOutput("up_busy4", int'(busy), 1);
        applyStimulus(0, 3'd0, 0, 0, 1);
        checkOutput("up_cnt5", int'(cnt), 5);
        checkOutput("up_done", int'(done), 1);
        applyStimulus(0, 3'd0, 0, 0, 1);
        checkOutput("up_done_pulse", int'(done), 0);

        // Down run 5 -> 2, then an equal target.
        applyStimulus(1, 3'd2, 0, 0, 1);
        checkOutput("dn_mode", int'(cnt_mode), 1);
        applyStimulus(0, 3'd0, 0, 0, 3);
        checkOutput("dn_cnt", int'(cnt), 2);
        checkOutput("dn_done", int'(done), 1);
        applyStimulus(0, 3'd0, 0, 0, 1);
        applyStimulus(1, 3'd2, 0, 0, 1);
        checkOutput("eq_done", int'(done), 1);
        checkOutput("eq_busy", int'(busy), 0);
        checkOutput("eq_cnt", int'(cnt), 2);
        applyStimulus(0, 3'd0, 0, 0, 1);

        // Return to 0, then run to 7 with a pause at 3.
        applyStimulus(1, 3'd0, 0, 0, 1);
        applyStimulus(0, 3'd0, 0, 0, 3);
        applyStimulus(1, 3'd7, 0, 0, 1);
        applyStimulus(0, 3'd0, 0, 0, 3);
        checkOutput("pz_cnt3", int'(cnt), 3);
        applyStimulus(0, 3'd0, 1, 0, 3);
        checkOutput("pz_hold", int'(cnt), 3);
        checkOutput("pz_busy", int'(busy), 1);
        checkOutput("pz_en", int'(cnt_en), 0);
        applyStimulus(0, 3'd0, 0, 0, 4);
        checkOutput("pz_cnt7", int'(cnt), 7);
        checkOutput("pz_done", int'(done), 1);
        applyStimulus(0, 3'd0, 0, 0, 1);

        // Back to 0, then abort (with pause) at 4.
        applyStimulus(1, 3'd0, 0, 0, 1);
        applyStimulus(0, 3'd0, 0, 0, 8);
        checkOutput("ab_start", int'(cnt), 0);
        applyStimulus(1, 3'd7, 0, 0, 1);
        applyStimulus(0, 3'd0, 0, 0, 4);
        checkOutput("ab_cnt4", int'(cnt), 4);
        applyStimulus(0, 3'd0, 1, 1, 1);
        checkOutput("ab_busy", int'(busy), 0);
        checkOutput("ab_cnt", int'(cnt), 4);
        checkOutput("ab_done", int'(done), 0);
        applyStimulus(0, 3'd0, 0, 1, 2);
        checkOutput("ab_idle_cnt", int'(cnt), 4);
        checkOutput("ab_idle_done", int'(done), 0);

        // Back-to-back: 4 -> 6 with valid held, then 6 -> 1 taken in DONE.
        applyStimulus(1, 3'd6, 0, 0, 1);
        applyStimulus(1, 3'd6, 0, 0, 2);
        checkOutput("bb_cnt6", int'(cnt), 6);
        checkOutput("bb_done", int'(done), 1);
        applyStimulus(1, 3'd1, 0, 0, 1);
        checkOutput("bb_busy", int'(busy), 1);
        checkOutput("bb_mode", int'(cnt_mode), 1);
        applyStimulus(0, 3'd0, 0, 0, 5);
        checkOutput("bb_cnt1", int'(cnt), 1);
        checkOutput("bb_done2", int'(done), 1);
        applyStimulus(0, 3'd0, 0, 0, 1);

        // Reset mid-run: 1 -> 6, reset at 3.
        applyStimulus(1, 3'd6, 0, 0, 1);
        applyStimulus(0, 3'd0, 0, 0, 2);
        checkOutput("mr_cnt3", int'(cnt), 3);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("mr_cnt", int'(cnt), 0);
        checkOutput("mr_busy", int'(busy), 0);
        checkOutput("mr_ready", int'(cmd_ready), 1);
        checkOutput("mr_done", int'(done), 0);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(1, 3'd2, 0, 0, 1);
        checkOutput("mr2_mode", int'(cnt_mode), 0);
        applyStimulus(0, 3'd0, 0, 0, 2);
        checkOutput("mr2_cnt", int'(cnt), 2);
        checkOutput("mr2_done", int'(done), 1);
        applyStimulus(0, 3'd0, 0, 0, 2);

        modelOn = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_updown_count_sequencer
